// File: rtl/hci_mem_bank_target_if.sv
// rtl/hci_mem_bank_target_if.sv - HCI size package and core channel interface
package hci_package;
   typedef struct packed {
      int unsigned DW;
      int unsigned AW;
      int unsigned BW;
      int unsigned UW;
      int unsigned IW;
      int unsigned EW;
      int unsigned EHW;
   } hci_size_parameter_t;
endpackage

interface hci_core_intf #(
   parameter int unsigned DW  = 32,
   parameter int unsigned AW  = 32,
   parameter int unsigned BW  = 8,
   parameter int unsigned UW  = 1,
   parameter int unsigned IW  = 1,
   parameter int unsigned EW  = 1,
   parameter int unsigned EHW = 1
) ();
   // Zero-width fields are carried as a single bit so the bundle stays legal
   localparam int unsigned UW_W  = (UW  > 0) ? UW  : 1;
   localparam int unsigned IW_W  = (IW  > 0) ? IW  : 1;
   localparam int unsigned EW_W  = (EW  > 0) ? EW  : 1;
   localparam int unsigned EHW_W = (EHW > 0) ? EHW : 1;

   logic                 req;
   logic                 gnt;
   logic [AW-1:0]        add;
   logic                 wen;
   logic [DW-1:0]        data;
   logic [DW/BW-1:0]     be;
   logic                 r_ready;
   logic [UW_W-1:0]      user;
   logic [IW_W-1:0]      id;
   logic [DW-1:0]        r_data;
   logic                 r_valid;
   logic [UW_W-1:0]      r_user;
   logic [IW_W-1:0]      r_id;
   logic                 r_opc;
   logic [EW_W-1:0]      ecc;
   logic [EW_W-1:0]      r_ecc;
   logic [EHW_W-1:0]     ereq;
   logic [EHW_W-1:0]     egnt;
   logic [EHW_W-1:0]     r_evalid;
   logic [EHW_W-1:0]     r_eready;

   modport target (
      input  req, add, wen, data, be, r_ready, user, id, ecc, ereq, r_eready,
      output gnt, r_data, r_valid, r_user, r_id, r_opc, r_ecc, egnt, r_evalid
   );

   modport initiator (
      output req, add, wen, data, be, r_ready, user, id, ecc, ereq, r_eready,
      input  gnt, r_data, r_valid, r_user, r_id, r_opc, r_ecc, egnt, r_evalid
   );
endinterface

// File: rtl/hci_mem_bank_target.sv
// rtl/hci_mem_bank_target.sv - single-ported TCDM bank responder with LFSR grant stalls
module hci_mem_bank_target #(
   parameter int unsigned                       NB_WORDS      = 1024,
   parameter logic [7:0]                        LFSR_SEED     = 8'hA5,
   parameter hci_package::hci_size_parameter_t  HCI_SIZE_tcdm = '0
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clear_i,
   input  logic         stall_en_i,
   input  logic [7:0]   stall_thresh_i,
   output logic [31:0]  nb_rd_o,
   output logic [31:0]  nb_wr_o,
   hci_core_intf.target tcdm
);
   localparam int unsigned IDX_W = $clog2(NB_WORDS);
   localparam int unsigned EHW   = HCI_SIZE_tcdm.EHW;

   logic [31:0]      mem [NB_WORDS];
   logic [IDX_W-1:0] idx;
   logic [7:0]       lfsr_q;
   logic             lfsr_fb;
   logic             stall;
   logic             gnt;
   logic             rd_acc;
   logic             wr_acc;
   logic             r_valid_q;
   logic [31:0]      r_data_q;
   logic [31:0]      nb_rd_q;
   logic [31:0]      nb_wr_q;
   logic             unused_in;

   // Only the word index matters; byte offset and high address bits alias
   assign idx     = tcdm.add[IDX_W+1:2];

   // Taps 8,6,5,4 give a maximal-length sequence that never visits zero
   assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

   assign stall   = stall_en_i & (lfsr_q < stall_thresh_i);
   assign gnt     = tcdm.req & ~stall;
   assign rd_acc  = gnt & tcdm.wen;
   assign wr_acc  = gnt & ~tcdm.wen;

   assign tcdm.gnt     = gnt;
   assign tcdm.r_valid = r_valid_q;
   assign tcdm.r_data  = r_data_q;
   assign tcdm.r_user  = '0;
   assign tcdm.r_id    = '0;
   assign tcdm.r_ecc   = '0;
   assign tcdm.r_opc   = 1'b0;
   assign nb_rd_o      = nb_rd_q;
   assign nb_wr_o      = nb_wr_q;

   // Response backpressure and sideband request fields have no effect here
   assign unused_in = ^{tcdm.add, tcdm.r_ready, tcdm.user, tcdm.id,
                        tcdm.ecc, tcdm.ereq, tcdm.r_eready};

   if (EHW > 0) begin : gen_ecc_hs
      assign tcdm.egnt     = gnt       ? '1 : '0;
      assign tcdm.r_evalid = r_valid_q ? '1 : '0;
   end else begin : gen_no_ecc_hs
      assign tcdm.egnt     = '1;
      assign tcdm.r_evalid = '0;
   end

   // Byte-masked array write; contents survive reset and clear
   always_ff @(posedge clk_i) begin
      if (wr_acc) begin
         for (int k = 0; k < 4; k++) begin
            if (tcdm.be[k]) begin
               mem[idx][8*k +: 8] <= tcdm.data[8*k +: 8];
            end
         end
      end
   end

   // Control state: LFSR, response register and saturating access counters
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lfsr_q    <= LFSR_SEED;
         r_valid_q <= 1'b0;
         r_data_q  <= '0;
         nb_rd_q   <= '0;
         nb_wr_q   <= '0;
      end else if (clear_i) begin
         lfsr_q    <= LFSR_SEED;
         r_valid_q <= 1'b0;
         r_data_q  <= '0;
         nb_rd_q   <= '0;
         nb_wr_q   <= '0;
      end else begin
         lfsr_q    <= {lfsr_q[6:0], lfsr_fb};
         r_valid_q <= gnt;
         if (rd_acc) begin
            r_data_q <= mem[idx];
         end
         if (rd_acc && (nb_rd_q != 32'hFFFF_FFFF)) begin
            nb_rd_q <= nb_rd_q + 32'd1;
         end
         if (wr_acc && (nb_wr_q != 32'hFFFF_FFFF)) begin
            nb_wr_q <= nb_wr_q + 32'd1;
         end
      end
   end
endmodule

// File: tb/tb_hci_mem_bank_target.sv
// tb/tb_hci_mem_bank_target.sv - scoreboard bench for hci_mem_bank_target
module tb_hci_mem_bank_target;
   localparam int         NB_WORDS = 1024;
   localparam logic [7:0] SEED     = 8'hA5;
   localparam hci_package::hci_size_parameter_t HSZ =
      '{DW: 32, AW: 32, BW: 8, UW: 1, IW: 1, EW: 1, EHW: 1};

   logic        clk = 1'b0;
   logic        rst;
   logic        clear;
   logic        stall_en;
   logic [7:0]  thresh;
   logic [31:0] nb_rd;
   logic [31:0] nb_wr;

   hci_core_intf #(.DW(32), .AW(32), .BW(8), .UW(1), .IW(1), .EW(1), .EHW(1)) tcdm ();

   hci_mem_bank_target #(
      .NB_WORDS(NB_WORDS), .LFSR_SEED(SEED), .HCI_SIZE_tcdm(HSZ)
   ) dut (
      .clk_i(clk), .rst_i(rst), .clear_i(clear), .stall_en_i(stall_en),
      .stall_thresh_i(thresh), .nb_rd_o(nb_rd), .nb_wr_o(nb_wr), .tcdm(tcdm)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   // Reference model state
   logic [7:0]  lfsr_tab [255];
   logic [7:0]  p;
   int          lfsr_pos;
   logic [31:0] mem_m [int];
   logic [31:0] rd_m, wr_m, last_rd;
   bit          cfg_en;
   logic [7:0]  cfg_th;
   typedef struct { bit rd; logic [31:0] d; } exp_t;
   exp_t        expq [$];
   exp_t        e_mon;

   task automatic model_reset();
      lfsr_pos = 0;
      rd_m     = 0;
      wr_m     = 0;
      last_rd  = 0;
      expq.delete();
   endtask

   // One bus cycle: drive at negedge, check grant, update model at the edge
   task automatic do_cycle(input bit rq, input bit wn, input logic [31:0] ad,
                           input logic [31:0] dt, input logic [3:0] b, input bit clr);
      bit   eg;
      int   idx;
      exp_t e;
      @(negedge clk);
      tcdm.req  = rq;
      tcdm.wen  = wn;
      tcdm.add  = ad;
      tcdm.data = dt;
      tcdm.be   = b;
      clear     = clr;
      stall_en  = cfg_en;
      thresh    = cfg_th;
      #1;
      eg = rq && !(cfg_en && (lfsr_tab[lfsr_pos] < cfg_th));
      chk("gnt", {31'd0, tcdm.gnt}, {31'd0, eg});
      chk("egnt", {31'd0, tcdm.egnt}, {31'd0, eg});
      @(posedge clk);
      idx = int'((ad >> 2) % NB_WORDS);
      if (eg && !wn) begin
         if (!mem_m.exists(idx)) mem_m[idx] = 'x;
         for (int k = 0; k < 4; k++)
            if (b[k]) mem_m[idx][8*k +: 8] = dt[8*k +: 8];
      end
      if (clr) begin
         model_reset();
      end else begin
         if (eg) begin
            e.rd = wn;
            e.d  = mem_m.exists(idx) ? mem_m[idx] : 'x;
            expq.push_back(e);
            if (wn) begin
               last_rd = e.d;
               if (rd_m != 32'hFFFF_FFFF) rd_m++;
            end else if (wr_m != 32'hFFFF_FFFF) begin
               wr_m++;
            end
         end
         lfsr_pos = (lfsr_pos + 1) % 255;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) do_cycle(0, 1, 0, 0, 0, 0);
   endtask

   task automatic chk_cnt(input string tag);
      #2;
      chk({tag, "_nb_rd"}, nb_rd, rd_m);
      chk({tag, "_nb_wr"}, nb_wr, wr_m);
   endtask

   // Monitor: every cycle, compare the response register to the scoreboard
   always @(posedge clk) begin
      #1;
      if (!rst) begin
         if (expq.size() > 0) begin
            e_mon = expq.pop_front();
            chk("r_valid", {31'd0, tcdm.r_valid}, 32'd1);
            chk("r_evalid", {31'd0, tcdm.r_evalid}, 32'd1);
            if (e_mon.rd) chk("rd_data", tcdm.r_data, e_mon.d);
         end else begin
            chk("r_valid_idle", {31'd0, tcdm.r_valid}, 32'd0);
         end
         chk("r_data_hold", tcdm.r_data, last_rd);
      end
   end

   initial begin
      rst = 1'b1; clear = 1'b0; stall_en = 1'b0; thresh = 8'h00;
      cfg_en = 1'b0; cfg_th = 8'h00;
      tcdm.req = 0; tcdm.wen = 1; tcdm.add = 0; tcdm.data = 0; tcdm.be = 0;
      tcdm.r_ready = 1; tcdm.user = 0; tcdm.id = 0; tcdm.ecc = 0;
      tcdm.ereq = 0; tcdm.r_eready = 1;
      lfsr_tab[0] = SEED;
      for (int i = 1; i < 255; i++) begin
         p = lfsr_tab[i-1];
         lfsr_tab[i] = {p[6:0], ^(p & 8'hB8)};
      end
      model_reset();
      @(posedge clk); @(posedge clk); #2;
      rst = 1'b0;

      // Reset then idle
      idle(10);
      chk("rst_nb_rd", nb_rd, 32'd0);
      chk("rst_nb_wr", nb_wr, 32'd0);
      chk("rst_r_data", tcdm.r_data, 32'd0);

      // Write then read
      do_cycle(1, 0, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
      do_cycle(1, 1, 32'h10, 32'h0, 4'h0, 0);
      #2 chk("wr_rd_data", tcdm.r_data, 32'hDEAD_BEEF);
      chk("wr_rd_nb_rd", nb_rd, 32'd1);
      chk("wr_rd_nb_wr", nb_wr, 32'd1);

      // Byte enables and aliasing
      do_cycle(1, 0, 32'h0,    32'h1122_3344, 4'hF,    0);
      do_cycle(1, 0, 32'h1000, 32'hAABB_CCDD, 4'b0101, 0);
      do_cycle(1, 1, 32'h0,    32'h0,         4'h0,    0);
      #2 chk("alias_data", tcdm.r_data, 32'h11BB_33DD);

      // Initialize every word, then stream 64 back-to-back reads
      for (int i = 0; i < NB_WORDS; i++) do_cycle(1, 0, i * 4, $urandom, 4'hF, 0);
      for (int i = 0; i < 64; i++) do_cycle(1, 1, i * 4, 0, 0, 0);
      chk_cnt("stream");

      // Stalls at threshold 0x80 with req held
      cfg_en = 1'b1; cfg_th = 8'h80;
      for (int i = 0; i < 256; i++) do_cycle(1, 1, $urandom_range(0, 63) * 4, 0, 0, 0);
      chk_cnt("stall80");
      cfg_th = 8'h00;
      for (int i = 0; i < 20; i++) do_cycle(1, 1, $urandom_range(0, 1023) * 4, 0, 0, 0);
      cfg_th = 8'hFF;
      for (int i = 0; i < 300; i++) do_cycle(1, 1, $urandom_range(0, 1023) * 4, 0, 0, 0);
      chk_cnt("stallFF");

      // Random mixed traffic with aliasing addresses and varying stall settings
      for (int blk = 0; blk < 8; blk++) begin
         cfg_en = $urandom_range(0, 1);
         cfg_th = $urandom;
         for (int i = 0; i < 50; i++)
            do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom,
                     $urandom, 4'($urandom), 0);
         chk_cnt("random");
      end

      // Clear during a granted write
      cfg_en = 1'b0;
      do_cycle(1, 0, 32'h40, 32'hCAFE_F00D, 4'hF, 1);
      do_cycle(0, 1, 0, 0, 0, 0);
      #2 chk("clr_nb_rd", nb_rd, 32'd0);
      chk("clr_nb_wr", nb_wr, 32'd0);
      do_cycle(1, 1, 32'h40, 0, 0, 0);
      #2 chk("clr_rd_data", tcdm.r_data, 32'hCAFE_F00D);

      // Asynchronous reset while a response is pending
      do_cycle(1, 1, 32'h10, 0, 0, 0);
      #2 chk("pre_rst_r_valid", {31'd0, tcdm.r_valid}, 32'd1);
      rst = 1'b1;
      #1 chk("async_rst_r_valid", {31'd0, tcdm.r_valid}, 32'd0);
      chk("async_rst_r_data", tcdm.r_data, 32'd0);
      model_reset();
      tcdm.req = 0;
      @(posedge clk); #2;
      rst = 1'b0;
      idle(5);
      chk_cnt("post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/hci_mem_bank_target.md
# hci_mem_bank_target

Single-ported TCDM memory bank model that acts as the responder at the far end of an HCI channel. It accepts 32-bit word requests on an `hci_core_intf.target` port, grants them in the same cycle, and returns read data with `r_valid` exactly one cycle after each grant. This is the per-bank target the router's `out[]` channels connect to. It adds programmable pseudo-random grant stalls and access counters so benches can stress arbitration and wrap-around paths upstream.

## Interface
- `NB_WORDS`, default 1024: bank depth in 32-bit words; power of 2, at least 2.
- `LFSR_SEED`, default 8'hA5: reset value of the stall LFSR; must be nonzero.
- `HCI_SIZE_tcdm`, default '0: HCI size parameter of the port. DW=32, BW=8, UW/IW/EW ignored, EHW honoured.
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset. One clock; reset is asynchronous and active-high.
- `clear_i`, in, 1: synchronous clear of control state (LFSR, response register, counters); memory contents are kept.
- `stall_en_i`, in, 1: enables grant stalling.
- `stall_thresh_i`, in, 8: a grant is denied when `lfsr_q < stall_thresh_i`.
- `nb_rd_o`, out, 32: count of granted reads.
- `nb_wr_o`, out, 32: count of granted writes.
- `tcdm`, `hci_core_intf.target`: request and response channel. `wen`=1 means read.

## Operation
- Word index: `add[$clog2(NB_WORDS)+1:2]`. Bits `add[1:0]` and all bits above the index are ignored, so addresses alias modulo `NB_WORDS*4`.
- Grant: `gnt = req & ~stall`, where `stall = stall_en_i & (lfsr_q < stall_thresh_i)`. The grant is purely combinational and does not depend on `r_ready`.
- Write (`req & gnt & ~wen`): byte k of `mem[idx]` is updated from `data[8k+7:8k]` for each byte with `be[k]`=1. With `be`=0 nothing is written, but the access is still counted and responded to.
- Read (`req & gnt & wen`): `r_data` is loaded with `mem[idx]` at the next clock edge.
- Response: `r_valid` is registered and equals `req & gnt` delayed by one cycle, for both reads and writes.
  - A write response leaves `r_data` at its previous value.
  - `r_data` holds its last read value until the next granted read.
  - `r_ready` is ignored; there is no response backpressure.
- LFSR: 8-bit Fibonacci LFSR, taps 8,6,5,4. It advances every cycle regardless of traffic, whether or not stalling is enabled, and its state never reaches 0.
- Counters: 32-bit saturating. `nb_rd_o` increments on each granted read and `nb_wr_o` on each granted write. Both hold at 32'hFFFFFFFF.
- Unused response fields: `r_user`, `r_id`, `r_ecc` and `r_opc` are 0.
- ECC handshake:
  - If EHW>0: `egnt` = `gnt` and `r_evalid` = `r_valid`, replicated across all EHW bits.
  - Otherwise: `egnt`='1 and `r_evalid`='0.
- Memory array: not reset. Reads of never-written words return X in simulation.

## Timing
- Reset values: `r_valid`=0, `r_data`=0, `lfsr_q`=`LFSR_SEED`, `nb_rd_o`=0, `nb_wr_o`=0.
  - `gnt` follows `req` combinationally: `gnt`=`req` when `stall_en_i`=0, otherwise it depends on the LFSR comparison.
- `clear_i` forces the same values as reset at the next edge. It takes priority over any access in that cycle: the memory write still happens, but `r_valid` and the counters are cleared.
- Latency: grant in cycle N, response (`r_valid`=1, data) in cycle N+1. Back-to-back grants give back-to-back `r_valid`, giving full throughput of 1 access per cycle.
- Read-after-write to the same index in consecutive cycles returns the newly written data. A write in cycle N commits at edge N→N+1, and a read granted in N+1 samples the array after that edge.
- An ungranted request has no side effects: no write, no response, no counter change.
- `stall_thresh_i`=0 never stalls. `stall_thresh_i`=8'hFF stalls on every LFSR value except 8'hFF.
- Asynchronous reset asserted mid-transaction: a pending `r_valid` is dropped immediately, and the response for the cycle-N grant is lost.

## Test plan
- Reset then idle: `rst_i` pulse, no `req` -> `r_valid`=0, `r_data`=0, `nb_rd_o`=`nb_wr_o`=0 for 10 cycles.
- Write then read:
  - Write `add`=0x10, `data`=0xDEADBEEF, `be`=4'hF, then read `add`=0x10 in the next cycle.
  - -> `gnt`=1 in both cycles, `r_valid` in cycles 2 and 3, `r_data`=0xDEADBEEF in cycle 3, `nb_wr_o`=1, `nb_rd_o`=1.
- Byte enables and aliasing:
  - With `NB_WORDS`=1024, write 0x11223344 to `add`=0x0, then write 0xAABBCCDD with `be`=4'b0101 to `add`=0x1000, then read `add`=0x0.
  - -> `r_data`=0x11BB33DD.
- Stalls:
  - Set `stall_en_i`=1, `stall_thresh_i`=8'h80, and hold `req`=1 for 256 cycles.
  - -> every cycle, `gnt` equals `lfsr_q`>=0x80 as computed by a reference LFSR model seeded with 8'hA5.
  - -> `r_valid` count equals `gnt` count, each `r_valid` follows its `gnt` by exactly 1 cycle, and `nb_rd_o` equals the `gnt` count.
- Streaming: 64 back-to-back granted reads of indices 0..63 after initialization -> 64 consecutive `r_valid` cycles with in-order data.
- Clear and reset mid-operation:
  - Assert `clear_i` during a granted write -> the next cycle shows `r_valid`=0 and counters=0, and a subsequent read returns the written data.
  - Assert `rst_i` asynchronously while `r_valid`=1 -> `r_valid` drops in the same cycle.
